// File: rtl/march_pkg.sv
// Shared definitions for the March C- BIST sequencer: FSM states and the
// per-element direction / polarity tables (bit i describes element i).
package march_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CMP  = 3'd2,
      ST_WR   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int unsigned NUM_ELEM  = 6;
   localparam logic [2:0]  ELEM_LAST = 3'd5;

   // E3..E5 walk downwards; E0 is write-only, E5 is read-only
   localparam logic [NUM_ELEM-1:0] ELEM_DOWN   = 6'b111000;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_RD = 6'b111110;
   localparam logic [NUM_ELEM-1:0] ELEM_HAS_WR = 6'b011111;
   localparam logic [NUM_ELEM-1:0] ELEM_RD_POL = 6'b010100;
   localparam logic [NUM_ELEM-1:0] ELEM_WR_POL = 6'b001010;

   localparam int unsigned RD_LATENCY = 1;

endpackage

// File: rtl/march_addr_gen.sv
// Up/down address counter for the March sequencer: loads the start address
// of an element, steps in the element's direction and flags its last address.
module march_addr_gen #(
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              load_down,
   input  logic              step,
   input  logic              down,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam logic [ADDR_W-1:0] ADDR_MIN = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] addr_r;

   // address register: reload at element start, step within an element
   always_ff @(posedge clk) begin
      if (!reset) begin
         addr_r <= ADDR_MIN;
      end else if (load) begin
         addr_r <= load_down ? ADDR_MAX : ADDR_MIN;
      end else if (step) begin
         addr_r <= down ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
      end else begin
         addr_r <= addr_r;
      end
   end

   // last address of the current walk direction
   always_comb begin
      if (down) begin
         last = (addr_r == ADDR_MIN);
      end else begin
         last = (addr_r == ADDR_MAX);
      end
   end

   assign addr = addr_r;

endmodule

// File: rtl/ram64x8_march_bist.sv
// March C- built-in self-test sequencer for the 64x8 single-port RAM;
// reports pass/fail and the first failing element, address and read data.
module ram64x8_march_bist
   import march_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 6,
   parameter int unsigned       DATA_W       = 8,
   parameter logic [DATA_W-1:0] BACKGROUND   = 8'h00,
   parameter bit                STOP_ON_FAIL = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              fail,
   output logic [2:0]        fail_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic [DATA_W-1:0] ram_data_in,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_enable,
   output logic              ram_read,
   input  logic [DATA_W-1:0] ram_data_out
);

   state_t            state_r, state_s, adv_state_s;
   logic [2:0]        elem_r, elem_s, elem_nx_s, adv_elem_s;
   logic              load_s, step_s, adv_load_s, adv_step_s;
   logic              load_down_s, down_s, last_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] rd_pat_s, wr_pat_s;
   logic              start_ok_s, mismatch_s, new_fail_s, finish_s;

   logic              busy_r, done_r, pass_r, fail_r;
   logic [2:0]        fail_elem_r;
   logic [ADDR_W-1:0] fail_addr_r;
   logic [DATA_W-1:0] fail_data_r;

   assign down_s      = ELEM_DOWN[elem_r];
   assign load_down_s = ELEM_DOWN[elem_s];
   assign elem_nx_s   = elem_r + 3'd1;
   assign start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign mismatch_s  = (state_r == ST_CMP) && (ram_data_out != rd_pat_s);
   assign new_fail_s  = mismatch_s && !fail_r;
   assign finish_s    = (state_s == ST_DONE) && (state_r != ST_DONE);

   march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (load_s),
      .load_down (load_down_s),
      .step      (step_s),
      .down      (down_s),
      .addr      (addr_s),
      .last      (last_s)
   );

   // expected read data and write data of the current element
   always_comb begin
      if (ELEM_RD_POL[elem_r]) begin
         rd_pat_s = ~BACKGROUND;
      end else begin
         rd_pat_s = BACKGROUND;
      end
      if (ELEM_WR_POL[elem_r]) begin
         wr_pat_s = ~BACKGROUND;
      end else begin
         wr_pat_s = BACKGROUND;
      end
   end

   // where to go once an address has finished its operations
   always_comb begin
      adv_state_s = state_r;
      adv_elem_s  = elem_r;
      adv_load_s  = 1'b0;
      adv_step_s  = 1'b0;
      if (!last_s) begin
         adv_state_s = ELEM_HAS_RD[elem_r] ? ST_RD : ST_WR;
         adv_step_s  = 1'b1;
      end else if (elem_r == ELEM_LAST) begin
         adv_state_s = ST_DONE;
      end else begin
         adv_state_s = ELEM_HAS_RD[elem_nx_s] ? ST_RD : ST_WR;
         adv_elem_s  = elem_nx_s;
         adv_load_s  = 1'b1;
      end
   end

   // FSM state and element registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         elem_r  <= 3'd0;
      end else begin
         state_r <= state_s;
         elem_r  <= elem_s;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_s = state_r;
      elem_s  = elem_r;
      load_s  = 1'b0;
      step_s  = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               elem_s  = 3'd0;
               load_s  = 1'b1;
               state_s = ELEM_HAS_RD[3'd0] ? ST_RD : ST_WR;
            end else begin
               state_s = state_r;
            end
         end
         ST_RD: begin
            state_s = ST_CMP;
         end
         ST_CMP: begin
            if (new_fail_s && STOP_ON_FAIL) begin
               state_s = ST_DONE;
            end else if (ELEM_HAS_WR[elem_r]) begin
               state_s = ST_WR;
            end else begin
               state_s = adv_state_s;
               elem_s  = adv_elem_s;
               load_s  = adv_load_s;
               step_s  = adv_step_s;
            end
         end
         ST_WR: begin
            state_s = adv_state_s;
            elem_s  = adv_elem_s;
            load_s  = adv_load_s;
            step_s  = adv_step_s;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // Moore decode of the RAM pins
   always_comb begin
      ram_enable  = 1'b0;
      ram_read    = 1'b0;
      ram_data_in = {DATA_W{1'b0}};
      case (state_r)
         ST_RD: begin
            ram_enable = 1'b1;
            ram_read   = 1'b1;
         end
         ST_WR: begin
            ram_enable  = 1'b1;
            ram_data_in = wr_pat_s;
         end
         default: begin
            ram_enable = 1'b0;
         end
      endcase
   end

   assign ram_address = addr_s;

   // status flags and first-failure capture
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         fail_elem_r <= 3'd0;
         fail_addr_r <= {ADDR_W{1'b0}};
         fail_data_r <= {DATA_W{1'b0}};
      end else if (start_ok_s) begin
         busy_r      <= 1'b1;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         fail_r      <= 1'b0;
         fail_elem_r <= 3'd0;
         fail_addr_r <= {ADDR_W{1'b0}};
         fail_data_r <= {DATA_W{1'b0}};
      end else begin
         if (new_fail_s) begin
            fail_r      <= 1'b1;
            fail_elem_r <= elem_r;
            fail_addr_r <= addr_s;
            fail_data_r <= ram_data_out;
         end
         // the final compare's own result must be folded into pass
         if (finish_s) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= ~(fail_r | mismatch_s);
         end
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign fail_elem = fail_elem_r;
   assign fail_addr = fail_addr_r;
   assign fail_data = fail_data_r;

endmodule
